// File: rtl/count_timestamp_capture_pkg.sv
// Shared widths, level-width helper and the {epoch, count} timestamp layout
// used by the timestamp capture block and its FIFO.
package count_ts_pkg;

    localparam int N_DEF   = 4;
    localparam int EXT_DEF = 4;
    localparam int TS_W    = N_DEF + EXT_DEF;

    // Width needed to hold 0..depth inclusive (a full FIFO must be representable).
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [EXT_DEF-1:0] epoch;
        logic [N_DEF-1:0]   count;
    } ts_t;

endpackage

// File: rtl/count_timestamp_capture_fifo.sv
// Small synchronous FIFO holding captured timestamps; head is read
// combinationally so a push into an empty FIFO is visible on the next cycle.
module ts_fifo
    import count_ts_pkg::*;
#(
    parameter int W     = TS_W,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                wdata,
    output logic [W-1:0]                rdata,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ts_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_MAX);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/count_timestamp_capture.sv
// Captures the upstream count on each synchronized rising edge of event_in,
// extends it with a wrap-count epoch and queues the result for readout.
module count_timestamp_capture
    import count_ts_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int EXT         = EXT_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N-1:0]                count_in,
    input  logic                        event_in,
    output logic [N+EXT-1:0]            ts_data,
    output logic                        ts_valid,
    input  logic                        ts_ready,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int TSW = N + EXT;

    typedef struct packed {
        logic [EXT-1:0] epoch;
        logic [N-1:0]   count;
    } stamp_t;

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("count_timestamp_capture: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   ev_edge;
    logic [N-1:0]           count_prev;
    logic                   wrap;
    logic [EXT-1:0]         epoch;
    logic [EXT-1:0]         epoch_eff;
    stamp_t                 capture;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ev_edge = sync_q[SYNC_STAGES-1] & ~sync_d;

    // A held count (pipeline fill) is not a wrap; only a strict decrease is.
    assign wrap      = (count_in < count_prev);
    assign epoch_eff = epoch + EXT'(wrap);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_prev <= '0;
            epoch      <= '0;
        end else begin
            count_prev <= count_in;
            epoch      <= epoch_eff;
        end
    end

    assign capture.epoch = epoch_eff;
    assign capture.count = count_in;

    assign ts_valid = ~fifo_empty;
    assign pop      = ts_valid & ts_ready;
    assign drop     = ev_edge & fifo_full & ~pop;

    ts_fifo #(
        .W     (TSW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev_edge),
        .pop   (pop),
        .wdata (capture),
        .rdata (ts_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_timestamp_capture.sv
// Bench for count_timestamp_capture: directed scenarios plus a randomized run
// against a queue-based reference model of the capture rules.
module tb_count_timestamp_capture;

    localparam int N     = 4;
    localparam int EXT   = 4;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  count_in;
    logic          event_in;
    logic [7:0]    ts_data;
    logic          ts_valid;
    logic          ts_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          overflow_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    int         pend[$];
    logic [3:0] m_prev;
    logic [3:0] m_epoch;
    logic       m_ev;
    logic       m_ov;
    int         cyc = 0;

    count_timestamp_capture #(
        .N(N), .EXT(EXT), .DEPTH(DEPTH), .SYNC_STAGES(S)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count_in     (count_in),
        .event_in     (event_in),
        .ts_data      (ts_data),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        pend.delete();
        m_prev  = '0;
        m_epoch = '0;
        m_ev    = 1'b0;
        m_ov    = 1'b0;
    endtask

    function automatic logic [7:0] exp_head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Drive one cycle of inputs, apply the capture rules at the edge, settle.
    task automatic step(input logic [3:0] c, input logic e, input logic r, input logic clr);
        logic wr, cap, pp, acc;
        count_in     = c;
        event_in     = e;
        ts_ready     = r;
        overflow_clr = clr;
        @(posedge clk);
        wr      = (c < m_prev);
        m_prev  = c;
        m_epoch = m_epoch + 4'(wr);
        cap     = 1'b0;
        if (pend.size() > 0 && pend[0] == cyc) begin
            cap = 1'b1;
            void'(pend.pop_front());
        end
        if (e && !m_ev) pend.push_back(cyc + S);
        m_ev = e;
        pp   = (mq.size() > 0) && r;
        acc  = cap && ((mq.size() < DEPTH) || pp);
        if (pp)  void'(mq.pop_front());
        if (acc) mq.push_back({m_epoch, c});
        if (cap && !acc) m_ov = 1'b1;
        else if (clr)    m_ov = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset_pulse();
        checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ts_valid); end
        checks++; if (ts_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", ts_data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single();
        reset_pulse();
        for (int i = 0; i < 10; i++) step(4'(i), (i >= 3 && i < 6), 1'b0, 1'b0);
        checks++; if (ts_data !== 8'h05) begin errors++; $display("FAIL single_data got %h want 05", ts_data); end
        checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ts_valid); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
        step(4'd10, 1'b0, 1'b0, 1'b0);
        checks++; if (ts_data !== 8'h05) begin errors++; $display("FAIL single_hold got %h want 05", ts_data); end
        step(4'd11, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level got %0d want 0", level); end
        checks++; if (ts_valid !== 1'b0 || ts_data !== 8'h00) begin errors++; $display("FAIL single_pop_empty got valid %b data %h want 0 00", ts_valid, ts_data); end
    endtask

    task automatic test_wrap();
        reset_pulse();
        for (int i = 0; i < 12; i++)
            step(4'((10 + i) % 16), (i == 4 || i == 5 || i == 7 || i == 8), 1'b0, 1'b0);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL wrap_level got %0d want 2", level); end
        checks++; if (ts_data !== 8'h10) begin errors++; $display("FAIL wrap_first got %h want 10", ts_data); end
        step(4'd6, 1'b0, 1'b1, 1'b0);
        checks++; if (ts_data !== 8'h13) begin errors++; $display("FAIL wrap_second got %h want 13", ts_data); end
        step(4'd7, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_drain got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        reset_pulse();
        for (int i = 0; i < 12; i++) step(4'(i), (i % 2 == 0 && i <= 8), 1'b0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        for (int j = 0; j < 4; j++) begin
            exp = 8'(2 + 2 * j);
            checks++; if (ts_data !== exp) begin errors++; $display("FAIL ovf_drain got %h want %h", ts_data, exp); end
            step(4'(12 + j), 1'b0, 1'b1, 1'b0);
        end
        checks++; if (level !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got level %0d ovf %b want 0 1", level, overflow); end
        step(4'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
        for (int j = 0; j < 11; j++) step(4'(1 + j), (j % 2 == 0 && j <= 8), 1'b0, (j == 10));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got %b want 1", overflow); end
        checks++; if (level !== 3'd4 || ts_data !== 8'h13) begin errors++; $display("FAIL ovf_refill got level %0d data %h want 4 13", level, ts_data); end
    endtask

    task automatic test_full_pop();
        logic [7:0] want [4];
        want[0] = 8'h15; want[1] = 8'h17; want[2] = 8'h19; want[3] = 8'h1F;
        step(4'd12, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL fullpop_pre got ovf %b level %0d want 0 4", overflow, level); end
        for (int j = 0; j < 3; j++) step(4'(13 + j), (j == 0), (j == 2), 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d want 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (ts_data !== want[j]) begin errors++; $display("FAIL fullpop_order got %h want %h", ts_data, want[j]); end
            step(4'(j), 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        for (int i = 0; i < 9; i++) step(4'((13 + i) % 16), (i == 3 || i == 4 || i == 6), 1'b0, 1'b0);
        checks++; if (level !== 3'd2 || ts_data !== 8'h12) begin errors++; $display("FAIL mid_pre got level %0d data %h want 2 12", level, ts_data); end
        reset = 1'b1;
        #2;
        checks++; if (ts_valid !== 1'b0 || ts_data !== 8'h00) begin errors++; $display("FAIL mid_async got valid %b data %h want 0 00", ts_valid, ts_data); end
        checks++; if (level !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_async_lvl got level %0d ovf %b want 0 0", level, overflow); end
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) step(4'(i), (i == 1 || i == 2), 1'b0, 1'b0);
        checks++; if (level !== 3'd1 || ts_data !== 8'h03) begin errors++; $display("FAIL mid_post got level %0d data %h want 1 03", level, ts_data); end
        step(4'd5, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_held();
        logic [LW-1:0] exp_lvl;
        reset_pulse();
        for (int i = 0; i < 14; i++) begin
            step(4'(i), (i < 10), 1'b0, 1'b0);
            exp_lvl = (i >= S) ? 3'd1 : 3'd0;
            checks++; if (level !== exp_lvl) begin errors++; $display("FAIL held_level i=%0d got %0d want %0d", i, level, exp_lvl); end
        end
        checks++; if (ts_data !== 8'h02) begin errors++; $display("FAIL held_data got %h want 02", ts_data); end
        step(4'd14, 1'b0, 1'b1, 1'b0);
        event_in = 1'b1;
        reset_pulse();
        for (int i = 0; i < 6; i++) step(4'(i), 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd1 || ts_data !== 8'h02) begin errors++; $display("FAIL held_reset got level %0d data %h want 1 02", level, ts_data); end
        step(4'd6, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic       e, r, clr;
        c = '0;
        e = 1'b0;
        reset_pulse();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) != 0) c = c + 4'd1;
            if ($urandom_range(0, 2) == 0) e = ~e;
            r   = (k < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_pulse();
                c = '0;
            end
            step(c, e, r, clr);
            checks++; if (ts_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid k=%0d got %b want %b", k, ts_valid, (mq.size() > 0)); end
            checks++; if (ts_data !== exp_head()) begin errors++; $display("FAIL rnd_data k=%0d got %h want %h", k, ts_data, exp_head()); end
            checks++; if (level !== LW'(mq.size())) begin errors++; $display("FAIL rnd_level k=%0d got %0d want %0d", k, level, mq.size()); end
            checks++; if (overflow !== m_ov) begin errors++; $display("FAIL rnd_overflow k=%0d got %b want %b", k, overflow, m_ov); end
        end
    endtask

    initial begin
        reset        = 1'b1;
        count_in     = '0;
        event_in     = 1'b0;
        ts_ready     = 1'b0;
        overflow_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
